idu_decode_queue: RTL

- Parametrised successor to the single-entry decode stage: a DEPTH-entry instruction queue between IFU and EXU, with full RV32I/RV32E decode of the head entry.
- Decouples fetch from RAW stalls, so the IFU keeps filling while the head waits on a hazard.
- Supports flush on control hazard and flags illegal register indices in E mode.
- Register file and CSR file live outside this block. This block only presents read indices and read-enable flags.

---
 rtl/idu_decode_queue_pkg.sv | 48 ++++
 rtl/idu_decode_queue_decoder.sv | 70 +++++++
 rtl/idu_decode_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/idu_decode_queue_pkg.sv
// idu_decode_queue_pkg: shared opcodes, ALU codes, operand-source enums and decoder control bundle
package idu_decode_queue_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_EQ   = 4'h9;
  localparam logic [3:0] ALU_NE   = 4'hA;
  localparam logic [3:0] ALU_LT   = 4'hB;
  localparam logic [3:0] ALU_GE   = 4'hC;
  localparam logic [3:0] ALU_LTU  = 4'hD;
  localparam logic [3:0] ALU_GEU  = 4'hE;
  localparam logic [3:0] ALU_NONE = 4'hF;
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_e;
  typedef enum logic [1:0] {B_RS2 = 2'd0, B_IMM = 2'd1, B_FOUR = 2'd2} alu_b_e;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] imm;
    logic [2:0]  func3;
    logic [3:0]  alu_op;
    alu_a_e      alu_a_src;
    alu_b_e      alu_b_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        zicsr;
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic        fence_i;
    logic        illegal;
  } idu_ctrl_t;
endpackage

// File: rtl/idu_decode_queue_decoder.sv
// idu_decoder: combinational RV32I/RV32E instruction to control-bundle decoder
// Ports: i_inst - instruction word; o_ctrl - register indices, use flags, immediate, ALU and class flags
module idu_decoder
  import idu_decode_queue_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic [31:0] i_inst,
  output idu_ctrl_t   o_ctrl
);
  localparam bit SMALL = NREG < 32;
  logic [2:0] w_f3;
  logic w_lui, w_auipc, w_jal, w_jalr, w_br, w_ld, w_st, w_alui, w_alur, w_sys, w_fence, w_csr;
  logic w_rw, w_r1, w_r2;
  logic [3:0] w_br_op;
  assign w_f3    = i_inst[14:12];
  assign w_lui   = i_inst[6:0] == OP_LUI;
  assign w_auipc = i_inst[6:0] == OP_AUIPC;
  assign w_jal   = i_inst[6:0] == OP_JAL;
  assign w_jalr  = i_inst[6:0] == OP_JALR;
  assign w_br    = i_inst[6:0] == OP_BRANCH;
  assign w_ld    = i_inst[6:0] == OP_LOAD;
  assign w_st    = i_inst[6:0] == OP_STORE;
  assign w_alui  = i_inst[6:0] == OP_ALU_I;
  assign w_alur  = i_inst[6:0] == OP_ALU_R;
  assign w_sys   = i_inst[6:0] == OP_SYSTEM;
  assign w_fence = i_inst[6:0] == OP_FENCE;
  assign w_csr   = w_sys & |w_f3;
  assign w_rw    = w_alur | w_ld | w_alui | w_jalr | w_lui | w_auipc | w_jal | w_csr;
  // csr*i forms carry a zero-extended immediate in the rs1 field, so rs1 is not read
  assign w_r1    = w_alur | w_st | w_br | w_ld | w_jalr | w_alui | (w_csr & ~i_inst[14]);
  assign w_r2    = w_alur | w_st | w_br;
  assign w_br_op = w_f3 == 3'd0 ? ALU_EQ  : w_f3 == 3'd1 ? ALU_NE  :
                   w_f3 == 3'd4 ? ALU_LT  : w_f3 == 3'd5 ? ALU_GE  :
                   w_f3 == 3'd6 ? ALU_LTU : w_f3 == 3'd7 ? ALU_GEU : ALU_NONE;
  always_comb begin
    o_ctrl = '0;
    o_ctrl.rs1       = i_inst[19:15];
    o_ctrl.rs2       = i_inst[24:20];
    o_ctrl.rd        = i_inst[11:7];
    o_ctrl.rs1_used  = w_r1;
    o_ctrl.rs2_used  = w_r2;
    o_ctrl.func3     = w_f3;
    o_ctrl.imm       = (w_ld | w_alui | w_jalr | w_csr) ? {{20{i_inst[31]}}, i_inst[31:20]} :
                       w_st ? {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]} :
                       w_br ? {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0} :
                       (w_lui | w_auipc) ? {i_inst[31:12], 12'h000} :
                       w_jal ? {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0} : 32'h0;
    // immediate shifts reuse bit 30 to select SRAI; other ALU_I ops treat it as immediate data
    o_ctrl.alu_op    = w_alur ? {i_inst[30], w_f3} :
                       w_alui ? {(w_f3 == 3'd5) & i_inst[30], w_f3} :
                       w_br ? w_br_op :
                       (w_ld | w_st | w_lui | w_auipc | w_jal | w_jalr) ? ALU_ADD : ALU_NONE;
    o_ctrl.alu_a_src = (w_auipc | w_jal | w_jalr) ? A_PC : w_lui ? A_ZERO : A_RS1;
    o_ctrl.alu_b_src = (w_jal | w_jalr) ? B_FOUR : (w_alui | w_ld | w_st | w_lui | w_auipc) ? B_IMM : B_RS2;
    o_ctrl.reg_write = w_rw;
    o_ctrl.mem_read  = w_ld;
    o_ctrl.mem_write = w_st;
    o_ctrl.branch    = w_br;
    o_ctrl.jal       = w_jal;
    o_ctrl.jalr      = w_jalr;
    o_ctrl.zicsr     = w_csr;
    o_ctrl.ecall     = i_inst == 32'h0000_0073;
    o_ctrl.ebreak    = i_inst == 32'h0010_0073;
    o_ctrl.mret      = i_inst == 32'h3020_0073;
    o_ctrl.fence_i   = w_fence & (w_f3 == 3'd1);
    o_ctrl.illegal   = ~(w_lui | w_auipc | w_jal | w_jalr | w_br | w_ld | w_st | w_alui | w_alur | w_sys | w_fence) |
                       (SMALL & ((w_rw & i_inst[11]) | (w_r1 & i_inst[19]) | (w_r2 & i_inst[24])));
  end
endmodule

// File: rtl/idu_decode_queue.sv
// idu_decode_queue: DEPTH-entry IFU->EXU instruction queue with combinational decode of the head entry
// Ports: clk/rst (sync, active-low); in_valid/in_ready/inst_i/pc_i/pc_predict_i from IFU;
//        flush, raw_stall from hazard unit; out_valid/out_ready plus head fields and decode to EXU;
//        occupancy reports the current entry count
module idu_decode_queue
  import idu_decode_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int NREG  = 16,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          inst_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          pc_predict_i,
  input  logic                     flush,
  input  logic                     raw_stall,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          pc_o,
  output logic [XLEN-1:0]          pc_predict_o,
  output logic [XLEN-1:0]          inst_o,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     rs1_used,
  output logic                     rs2_used,
  output logic [XLEN-1:0]          imm,
  output logic [2:0]               func3,
  output logic [3:0]               alu_op,
  output logic [1:0]               alu_a_src,
  output logic [1:0]               alu_b_src,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     branch,
  output logic                     jal,
  output logic                     jalr,
  output logic                     zicsr,
  output logic                     ecall,
  output logic                     ebreak,
  output logic                     mret,
  output logic                     fence_i,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] r_pc [DEPTH];
  logic [XLEN-1:0] r_pp [DEPTH];
  logic [XLEN-1:0] r_inst [DEPTH];
  logic [AW-1:0] r_wr, r_rd, w_wr_nx, w_rd_nx;
  logic [CW-1:0] r_cnt;
  logic w_push, w_pop;
  idu_ctrl_t w_ctrl;
  assign in_ready  = r_cnt != CW'(DEPTH);
  assign out_valid = (r_cnt != '0) & ~raw_stall & ~flush;
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;
  assign w_wr_nx   = r_wr == AW'(DEPTH - 1) ? '0 : r_wr + 1'b1;
  assign w_rd_nx   = r_rd == AW'(DEPTH - 1) ? '0 : r_rd + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]   <= '0;
        r_pp[k]   <= '0;
        r_inst[k] <= '0;
      end
    end else if (flush) begin
      r_cnt <= '0;
      r_rd  <= r_wr;
    end else begin
      if (w_push) begin
        r_pc[r_wr]   <= pc_i;
        r_pp[r_wr]   <= pc_predict_i;
        r_inst[r_wr] <= inst_i;
        r_wr         <= w_wr_nx;
      end
      if (w_pop) r_rd <= w_rd_nx;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
  idu_decoder #(.NREG(NREG)) u_dec (.i_inst(r_inst[r_rd]), .o_ctrl(w_ctrl));
  assign pc_o         = r_pc[r_rd];
  assign pc_predict_o = r_pp[r_rd];
  assign inst_o       = r_inst[r_rd];
  assign occupancy    = r_cnt;
  assign rs1          = w_ctrl.rs1;
  assign rs2          = w_ctrl.rs2;
  assign rd           = w_ctrl.rd;
  assign rs1_used     = w_ctrl.rs1_used;
  assign rs2_used     = w_ctrl.rs2_used;
  assign imm          = w_ctrl.imm;
  assign func3        = w_ctrl.func3;
  assign alu_op       = w_ctrl.alu_op;
  assign alu_a_src    = w_ctrl.alu_a_src;
  assign alu_b_src    = w_ctrl.alu_b_src;
  assign reg_write    = w_ctrl.reg_write;
  assign mem_read     = w_ctrl.mem_read;
  assign mem_write    = w_ctrl.mem_write;
  assign branch       = w_ctrl.branch;
  assign jal          = w_ctrl.jal;
  assign jalr         = w_ctrl.jalr;
  assign zicsr        = w_ctrl.zicsr;
  assign ecall        = w_ctrl.ecall;
  assign ebreak       = w_ctrl.ebreak;
  assign mret         = w_ctrl.mret;
  assign fence_i      = w_ctrl.fence_i;
  assign illegal      = w_ctrl.illegal;
endmodule
